// File: rtl/gcn_engine.sv
// Graph-convolution engine: loads weight columns and feature rows, forms FM x WM,
// aggregates over an undirected COO edge list and reports a per-node argmax class.
module gcn_engine #(
  parameter int unsigned FEATURE_COLS      = 96,
  parameter int unsigned FEATURE_ROWS      = 6,
  parameter int unsigned WEIGHT_COLS       = 3,
  parameter int unsigned FEATURE_WIDTH     = 5,
  parameter int unsigned WEIGHT_WIDTH      = 5,
  parameter int unsigned DOT_PROD_WIDTH    = 16,
  parameter int unsigned AGG_WIDTH         = 19,
  parameter int unsigned ADDRESS_WIDTH     = 13,
  parameter int unsigned FEATURE_BASE      = 512,
  parameter int unsigned NUM_EDGES         = 6,
  parameter int unsigned EDGE_BW           = $clog2(NUM_EDGES),
  parameter int unsigned NODE_BW           = $clog2(FEATURE_ROWS),
  parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS),
  localparam int unsigned DATA_WIDTH =
      (FEATURE_WIDTH > WEIGHT_WIDTH) ? FEATURE_WIDTH : WEIGHT_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [FEATURE_COLS-1:0][DATA_WIDTH-1:0]          data_in,
  input  logic [1:0][NODE_BW-1:0]                          coo_in,
  output logic [ADDRESS_WIDTH-1:0]                         read_address,
  output logic                                             enable_read,
  output logic [EDGE_BW-1:0]                               coo_address,
  output logic                                             busy,
  output logic                                             done,
  output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]   max_addi_answer
);

  localparam int unsigned MaxWf  = (WEIGHT_COLS > FEATURE_ROWS) ? WEIGHT_COLS : FEATURE_ROWS;
  localparam int unsigned MaxLen = (MaxWf > NUM_EDGES) ? MaxWf : NUM_EDGES;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam int unsigned ProdW  = FEATURE_WIDTH + WEIGHT_WIDTH;

  // Phase counters run 0..N: issue while below N, drain on N.
  localparam logic [CntW-1:0] WEnd = CntW'(WEIGHT_COLS);
  localparam logic [CntW-1:0] FEnd = CntW'(FEATURE_ROWS);
  localparam logic [CntW-1:0] EEnd = CntW'(NUM_EDGES);

  typedef enum logic [2:0] {StIdle, StLoadW, StCompute, StAgg, StArgmax, StDone} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [ADDRESS_WIDTH-1:0] read_address_q;
  logic [EDGE_BW-1:0]       coo_address_q;
  logic                     coo_issue;
  logic                     rd_valid_q, coo_valid_q;
  logic [CntW-1:0]          rd_idx_q;

  logic [WEIGHT_COLS-1:0][FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0] weight_q;
  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fmwm_q;
  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][AGG_WIDTH-1:0] agg_q, agg_d;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] dot;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_s, row_d;
  logic                                       s_ok, d_ok;
  logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] ans_q, ans_d;
  logic [AGG_WIDTH-1:0]                       best_v;

  function automatic logic [ProdW-1:0] mul(input logic [FEATURE_WIDTH-1:0] a,
                                           input logic [WEIGHT_WIDTH-1:0]  b);
    return {{WEIGHT_WIDTH{1'b0}}, a} * {{FEATURE_WIDTH{1'b0}}, b};
  endfunction

  // FSM state and phase counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each phase ends after its drain cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    case (state_q)
      StIdle, StDone: begin
        cnt_d = '0;
        if (start) state_d = StLoadW;
      end
      StLoadW:   if (cnt_q == WEnd) begin state_d = StCompute; cnt_d = '0; end
      StCompute: if (cnt_q == FEnd) begin state_d = StAgg;     cnt_d = '0; end
      StAgg:     if (cnt_q == EEnd) begin state_d = StArgmax;  cnt_d = '0; end
      StArgmax:  begin state_d = StDone; cnt_d = '0; end
      default:   begin state_d = StIdle; cnt_d = '0; end
    endcase
  end

  // Outputs: read/edge requests; addresses hold their last value when idle.
  always_comb begin
    busy         = (state_q != StIdle) && (state_q != StDone);
    done         = (state_q == StDone);
    enable_read  = 1'b0;
    coo_issue    = 1'b0;
    read_address = read_address_q;
    coo_address  = coo_address_q;
    case (state_q)
      StLoadW: if (cnt_q < WEnd) begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(cnt_q);
      end
      StCompute: if (cnt_q < FEnd) begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(cnt_q);
      end
      StAgg: if (cnt_q < EEnd) begin
        coo_issue   = 1'b1;
        coo_address = EDGE_BW'(cnt_q);
      end
      default: ;
    endcase
  end

  // Request tracking: remember what was asked for so the returning data can be routed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_address_q <= '0;
      coo_address_q  <= '0;
      rd_valid_q     <= 1'b0;
      coo_valid_q    <= 1'b0;
      rd_idx_q       <= '0;
    end else begin
      read_address_q <= read_address;
      coo_address_q  <= coo_address;
      rd_valid_q     <= enable_read;
      coo_valid_q    <= coo_issue;
      rd_idx_q       <= cnt_q;
    end
  end

  // All WEIGHT_COLS dot products of the returning feature row, truncated to DOT_PROD_WIDTH.
  always_comb begin
    dot = '0;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      for (int k = 0; k < FEATURE_COLS; k++) begin
        dot[c] = dot[c] + DOT_PROD_WIDTH'(mul(data_in[k][FEATURE_WIDTH-1:0], weight_q[c][k]));
      end
    end
  end

  // Weight scratchpad and FM x WM capture, one cycle after each read request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_q <= '0;
      fmwm_q   <= '0;
    end else begin
      if (state_q == StLoadW && rd_valid_q) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          if (rd_idx_q == CntW'(c)) begin
            for (int k = 0; k < FEATURE_COLS; k++) begin
              weight_q[c][k] <= data_in[k][WEIGHT_WIDTH-1:0];
            end
          end
        end
      end
      if (state_q == StCompute && rd_valid_q) begin
        for (int r = 0; r < FEATURE_ROWS; r++) begin
          if (rd_idx_q == CntW'(r)) fmwm_q[r] <= dot;
        end
      end
    end
  end

  // Aggregation: undirected edge adds both ways; self-loops once; out-of-range nodes drop the edge.
  always_comb begin
    row_s = '0;
    row_d = '0;
    s_ok  = 1'b0;
    d_ok  = 1'b0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (coo_in[0] == NODE_BW'(r)) begin row_s = fmwm_q[r]; s_ok = 1'b1; end
      if (coo_in[1] == NODE_BW'(r)) begin row_d = fmwm_q[r]; d_ok = 1'b1; end
    end
    agg_d = agg_q;
    if (state_q == StCompute && cnt_q == FEnd) begin
      agg_d = '0;
    end else if (state_q == StAgg && coo_valid_q && s_ok && d_ok) begin
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          if (coo_in[1] == NODE_BW'(n)) begin
            agg_d[n][c] = agg_q[n][c] + AGG_WIDTH'(row_s[c]);
          end
          if (coo_in[0] == NODE_BW'(n) && coo_in[0] != coo_in[1]) begin
            agg_d[n][c] = agg_q[n][c] + AGG_WIDTH'(row_d[c]);
          end
        end
      end
    end
  end

  // Aggregate register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) agg_q <= '0;
    else        agg_q <= agg_d;
  end

  // Per-node argmax; strict compare keeps the lowest class on ties.
  always_comb begin
    ans_d  = '0;
    best_v = '0;
    for (int n = 0; n < FEATURE_ROWS; n++) begin
      best_v = agg_q[n][0];
      for (int c = 1; c < WEIGHT_COLS; c++) begin
        if (agg_q[n][c] > best_v) begin
          best_v   = agg_q[n][c];
          ans_d[n] = MAX_ADDRESS_WIDTH'(c);
        end
      end
    end
  end

  // Answers update only on the ARGMAX cycle and hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    ans_q <= '0;
    else if (state_q == StArgmax)  ans_q <= ans_d;
  end

  assign max_addi_answer = ans_q;

endmodule

// File: tb/tb_gcn_engine.sv
// Scoreboard bench for gcn_engine: stimulus pushes expected answers, a negedge
// monitor pops and checks them (plus latency and read sequence) whenever done rises.
module tb_gcn_engine;

  localparam int FC = 96;
  localparam int FR = 6;
  localparam int WC = 3;
  localparam int NE = 6;
  localparam int Latency = 19;

  typedef logic [FR-1:0][1:0] ans_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [FC-1:0][4:0] data_in;
  logic [1:0][2:0]    coo_in;
  logic [12:0]        read_address;
  logic               enable_read;
  logic [2:0]         coo_address;
  logic               busy;
  logic               done;
  ans_t               max_addi_answer;

  gcn_engine dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .data_in         (data_in),
    .coo_in          (coo_in),
    .read_address    (read_address),
    .enable_read     (enable_read),
    .coo_address     (coo_address),
    .busy            (busy),
    .done            (done),
    .max_addi_answer (max_addi_answer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wmem [WC][FC];
  int fmem [FR][FC];
  int esrc [NE];
  int edst [NE];

  int n_checks = 0;
  int n_fail   = 0;
  ans_t exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [FC-1:0][4:0] mem_row(input int a);
    logic [FC-1:0][4:0] v;
    v = '0;
    for (int k = 0; k < FC; k++) begin
      if (a < WC) v[k] = 5'(wmem[a][k]);
      else if (a >= 512 && a < 512 + FR) v[k] = 5'(fmem[a-512][k]);
    end
    return v;
  endfunction

  function automatic logic [1:0][2:0] coo_word(input int e);
    logic [1:0][2:0] w;
    w = '0;
    if (e < NE) w = {3'(edst[e]), 3'(esrc[e])};
    return w;
  endfunction

  function automatic ans_t pack_ans(input int a0, input int a1, input int a2,
                                    input int a3, input int a4, input int a5);
    ans_t v;
    v = {2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
    return v;
  endfunction

  function automatic int exp_addr(input int i);
    return (i < WC) ? i : 512 + i - WC;
  endfunction

  // Memory model: request sampled mid-cycle, data presented from the next edge.
  initial begin : memory
    logic req_en;
    int   req_addr;
    int   req_coo;
    forever begin
      @(negedge clk);
      req_en   = enable_read;
      req_addr = int'(read_address);
      req_coo  = int'(coo_address);
      @(posedge clk);
      if (req_en) data_in <= mem_row(req_addr);
      coo_in <= coo_word(req_coo);
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    int   e0;
    int   rd_count;
    int   rd_addr[$];
    logic done_prev;
    logic relaunch_chk;
    ans_t e;
    ans_t last_ans;
    e0 = 0; rd_count = 0; done_prev = 1'b0; relaunch_chk = 1'b0; last_ans = '0;
    forever begin
      @(negedge clk);
      if (relaunch_chk) begin
        check("relaunch done low", longint'(done), 0);
        check("relaunch busy", longint'(busy), 1);
        check("answers held into next run", longint'(max_addi_answer), longint'(last_ans));
        relaunch_chk = 1'b0;
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected done: got done with no run pending, want none");
        end else begin
          e = exp_q.pop_front();
          last_ans = e;
          for (int n = 0; n < FR; n++) begin
            check($sformatf("answer[%0d]", n), longint'(max_addi_answer[n]), longint'(e[n]));
          end
          check("done latency", cyc - e0, Latency);
          check("read count", rd_count, FC > 0 ? WC + FR : 0);
          for (int i = 0; i < WC + FR; i++) begin
            check($sformatf("read address %0d", i),
                  (i < rd_addr.size()) ? rd_addr[i] : -1, exp_addr(i));
          end
        end
        if (start) relaunch_chk = 1'b1;
      end
      done_prev = done;
      if (enable_read) begin
        rd_count++;
        rd_addr.push_back(int'(read_address));
      end
      if (start && !busy && reset) begin
        e0 = cyc + 1;
        rd_count = 0;
        rd_addr.delete();
      end
    end
  end

  task automatic set_ring_mem();
    for (int k = 0; k < FC; k++) begin
      for (int c = 0; c < WC; c++) wmem[c][k] = (k == c) ? 1 : 0;
      for (int r = 0; r < FR; r++) fmem[r][k] = (k == r % 3) ? 10 : 0;
    end
  endtask

  task automatic set_flat_mem(input int f, input int w0, input int w1, input int w2);
    for (int k = 0; k < FC; k++) begin
      wmem[0][k] = w0; wmem[1][k] = w1; wmem[2][k] = w2;
      for (int r = 0; r < FR; r++) fmem[r][k] = f;
    end
  endtask

  task automatic set_ring_edges();
    for (int e = 0; e < NE; e++) begin
      esrc[e] = e;
      edst[e] = (e + 1) % FR;
    end
  endtask

  task automatic set_edge(input int e, input int s, input int d);
    esrc[e] = s;
    edst[e] = d;
  endtask

  task automatic launch();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run timeout: got %0d results outstanding after %0d cycles, want 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input ans_t e);
    exp_q.push_back(e);
    launch();
    wait_drain(60);
  endtask

  initial begin : stimulus
    int n;
    #2 reset = 1'b0;
    #20;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset enable_read", longint'(enable_read), 0);
    check("reset read_address", longint'(read_address), 0);
    check("reset coo_address", longint'(coo_address), 0);
    check("reset answers", longint'(max_addi_answer), 0);
    @(posedge clk); #1 reset = 1'b1;

    // Ring: two-way ties resolve to the lower class.
    set_ring_mem();
    set_ring_edges();
    run(pack_ans(1, 0, 0, 1, 0, 0));

    // Self-loop on node 1 replaces (5,0); node 5 keeps edge (4,5) and sees class 1.
    set_edge(5, 1, 1);
    run(pack_ans(1, 0, 0, 1, 0, 1));

    // Out-of-range source node: edge dropped, same as the ring without (5,0).
    set_edge(5, 7, 0);
    run(pack_ans(1, 0, 0, 1, 0, 1));

    // Overflow: every fmwm element wraps to 26720; all classes equal.
    set_flat_mem(31, 31, 31, 31);
    for (int e = 0; e < NE; e++) set_edge(e, 7, 7);
    set_edge(0, 0, 1);
    run(pack_ans(0, 0, 0, 0, 0, 0));

    // Wrap decides the winner: 92256->26720, 89280->23744, 59520 unwrapped.
    set_flat_mem(31, 31, 30, 20);
    run(pack_ans(2, 2, 0, 0, 0, 0));

    // start pulsed during AGG must be ignored.
    set_ring_mem();
    set_ring_edges();
    exp_q.push_back(pack_ans(1, 0, 0, 1, 0, 0));
    launch();
    repeat (13) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_drain(60);
    repeat (25) @(posedge clk);
    #1;
    check("no extra run busy", longint'(busy), 0);
    check("no extra run done", longint'(done), 1);

    // start held high through DONE relaunches immediately.
    exp_q.push_back(pack_ans(1, 0, 0, 1, 0, 0));
    exp_q.push_back(pack_ans(1, 0, 0, 1, 0, 0));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("held start reaches done", longint'(done), 1);
    @(posedge clk); #1 start = 1'b0;
    wait_drain(60);

    // Asynchronous reset in the middle of COMPUTE.
    launch();
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort busy", longint'(busy), 0);
    check("abort done", longint'(done), 0);
    check("abort enable_read", longint'(enable_read), 0);
    check("abort read_address", longint'(read_address), 0);
    check("abort coo_address", longint'(coo_address), 0);
    check("abort answers", longint'(max_addi_answer), 0);
    @(posedge clk); #1 reset = 1'b1;

    // Recovery after reset.
    run(pack_ans(1, 0, 0, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no summary by 100000 ns, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
